// File: rtl/id_ctrl_decode.sv
// Decode-stage control for the ARM pipeline: field decode, src2 select,
// condition/hazard bubble insertion and the ID/EX control register.
module id_ctrl_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        cond_pass,
    input  logic        hazard,
    input  logic        flush,
    output logic [3:0]  src2,
    output logic        two_src,
    output logic [3:0]  exe_cmd,
    output logic        wb_en,
    output logic        mem_read,
    output logic        mem_write,
    output logic        b,
    output logic        s,
    output logic [3:0]  ex_exe_cmd,
    output logic        ex_wb_en,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_b,
    output logic        ex_s
);

    localparam int unsigned BUNDLE_W = 9;

    logic [1:0]          w_mode;
    logic [3:0]          w_opcode;
    logic                w_s_bit;
    logic                w_imm;
    logic [3:0]          w_exe_cmd;
    logic                w_wb_en;
    logic                w_mem_read;
    logic                w_mem_write;
    logic                w_b;
    logic                w_s;
    logic                w_bubble;
    logic [BUNDLE_W-1:0] w_bundle;
    logic [BUNDLE_W-1:0] r_ex;

    assign w_mode   = instruction[27:26];
    assign w_opcode = instruction[24:21];
    assign w_s_bit  = instruction[20];
    assign w_imm    = instruction[25];

    // Raw (pre-bubble) decode of mode/opcode/S
    always_comb begin
        w_exe_cmd   = 4'b0000;
        w_wb_en     = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_b         = 1'b0;
        w_s         = 1'b0;
        case (w_mode)
            2'b00: begin
                w_s = w_s_bit;
                case (w_opcode)
                    4'b1101: begin w_exe_cmd = 4'b0001; w_wb_en = 1'b1; end
                    4'b1111: begin w_exe_cmd = 4'b1001; w_wb_en = 1'b1; end
                    4'b0100: begin w_exe_cmd = 4'b0010; w_wb_en = 1'b1; end
                    4'b0101: begin w_exe_cmd = 4'b0011; w_wb_en = 1'b1; end
                    4'b0010: begin w_exe_cmd = 4'b0100; w_wb_en = 1'b1; end
                    4'b0110: begin w_exe_cmd = 4'b0101; w_wb_en = 1'b1; end
                    4'b0000: begin w_exe_cmd = 4'b0110; w_wb_en = 1'b1; end
                    4'b1100: begin w_exe_cmd = 4'b0111; w_wb_en = 1'b1; end
                    4'b0001: begin w_exe_cmd = 4'b1000; w_wb_en = 1'b1; end
                    4'b1010: w_exe_cmd = 4'b0100;
                    4'b1000: w_exe_cmd = 4'b0110;
                    default: ;
                endcase
            end
            2'b01: begin
                w_exe_cmd = 4'b0010;
                if (w_s_bit) begin
                    w_mem_read = 1'b1;
                    w_wb_en    = 1'b1;
                end else begin
                    w_mem_write = 1'b1;
                end
            end
            2'b10:   w_b = 1'b1;
            default: ;
        endcase
    end

    // src2/two_src use the raw decode so hazard never loops back combinationally
    assign src2    = w_mem_write ? instruction[15:12] : instruction[3:0];
    assign two_src = ~w_imm | w_mem_write;

    assign w_bubble = ~cond_pass | hazard;
    assign w_bundle = w_bubble ? BUNDLE_W'(0)
                               : {w_s, w_b, w_exe_cmd, w_mem_write, w_mem_read, w_wb_en};

    assign {s, b, exe_cmd, mem_write, mem_read, wb_en} = w_bundle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex <= BUNDLE_W'(0);
        end else if (flush) begin
            r_ex <= BUNDLE_W'(0);
        end else begin
            r_ex <= w_bundle;
        end
    end

    assign {ex_s, ex_b, ex_exe_cmd, ex_mem_write, ex_mem_read, ex_wb_en} = r_ex;

endmodule

// File: tb/tb_id_ctrl_decode.sv
// Self-checking bench for id_ctrl_decode: directed cases then random
// instructions against a table-driven reference model.
module tb_id_ctrl_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic        cond_pass;
    logic        hazard;
    logic        flush;
    logic [3:0]  src2;
    logic        two_src;
    logic [3:0]  exe_cmd;
    logic        wb_en, mem_read, mem_write, b, s;
    logic [3:0]  ex_exe_cmd;
    logic        ex_wb_en, ex_mem_read, ex_mem_write, ex_b, ex_s;

    int compared = 0;
    int mismatched = 0;

    logic [3:0] op_exe [16];
    logic       op_wb  [16];
    logic [8:0] exp_ex;

    id_ctrl_decode dut (
        .clk(clk), .rst(rst), .instruction(instruction), .cond_pass(cond_pass),
        .hazard(hazard), .flush(flush), .src2(src2), .two_src(two_src),
        .exe_cmd(exe_cmd), .wb_en(wb_en), .mem_read(mem_read), .mem_write(mem_write),
        .b(b), .s(s), .ex_exe_cmd(ex_exe_cmd), .ex_wb_en(ex_wb_en),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_b(ex_b), .ex_s(ex_s)
    );

    always #5 clk = ~clk;

    wire [8:0] obs_bundle = {s, b, exe_cmd, mem_write, mem_read, wb_en};
    wire [8:0] obs_ex     = {ex_s, ex_b, ex_exe_cmd, ex_mem_write, ex_mem_read, ex_wb_en};

    // Reference: is this a store (raw)?
    function automatic logic ref_store(input logic [31:0] ins);
        return (ins[27:26] == 2'b01) && !ins[20];
    endfunction

    // Reference: raw bundle {s,b,exe_cmd,mem_write,mem_read,wb_en} from the mnemonic table
    function automatic logic [8:0] ref_raw(input logic [31:0] ins);
        logic [8:0] r;
        r = 9'd0;
        if (ins[27:26] == 2'b00)
            r = {ins[20], 1'b0, op_exe[ins[24:21]], 1'b0, 1'b0, op_wb[ins[24:21]]};
        else if (ins[27:26] == 2'b01)
            r = ins[20] ? {2'b00, 4'b0010, 3'b011} : {2'b00, 4'b0010, 3'b100};
        else if (ins[27:26] == 2'b10)
            r = 9'b0_1_0000_000;
        return r;
    endfunction

    task automatic chk9(input string tag, input logic [8:0] obs, input logic [8:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: got %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Apply one instruction for one cycle; check comb outputs then ID/EX
    task automatic step(input logic [31:0] ins, input logic cp, input logic hz, input logic fl);
        logic [8:0] bnd;
        @(negedge clk);
        instruction = ins; cond_pass = cp; hazard = hz; flush = fl;
        #1;
        bnd = (!cp || hz) ? 9'd0 : ref_raw(ins);
        chk9("bundle", obs_bundle, bnd);
        chk4("src2", src2, ref_store(ins) ? ins[15:12] : ins[3:0]);
        chk4("two_src", {3'b000, two_src}, {3'b000, ~ins[25] | ref_store(ins)});
        exp_ex = fl ? 9'd0 : bnd;
        @(posedge clk);
        #1;
        chk9("ex_bundle", obs_ex, exp_ex);
    endtask

    // Mid-cycle reset pulse: ex_* must clear before any clock edge
    task automatic mid_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk9("ex_async_rst", obs_ex, 9'd0);
        @(posedge clk);
        #1;
        chk9("ex_hold_rst", obs_ex, 9'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_ex = 9'd0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin op_exe[i] = 4'b0000; op_wb[i] = 1'b0; end
        op_exe[13] = 4'b0001; op_wb[13] = 1'b1;
        op_exe[15] = 4'b1001; op_wb[15] = 1'b1;
        op_exe[4]  = 4'b0010; op_wb[4]  = 1'b1;
        op_exe[5]  = 4'b0011; op_wb[5]  = 1'b1;
        op_exe[2]  = 4'b0100; op_wb[2]  = 1'b1;
        op_exe[6]  = 4'b0101; op_wb[6]  = 1'b1;
        op_exe[0]  = 4'b0110; op_wb[0]  = 1'b1;
        op_exe[12] = 4'b0111; op_wb[12] = 1'b1;
        op_exe[1]  = 4'b1000; op_wb[1]  = 1'b1;
        op_exe[10] = 4'b0100;
        op_exe[8]  = 4'b0110;

        rst = 1'b1; instruction = 32'hE0821003; cond_pass = 1'b1; hazard = 1'b0; flush = 1'b0;
        #1;
        chk9("reset_ex", obs_ex, 9'd0);
        repeat (2) @(posedge clk);
        #1;
        chk9("reset_ex_held", obs_ex, 9'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        step(32'hE0821003, 1'b1, 1'b0, 1'b0);
        chk9("add_ex_const", obs_ex, 9'b0_0_0010_001);
        step(32'hE5812000, 1'b1, 1'b0, 1'b0);
        chk4("str_src2", src2, 4'h2);
        step(32'hE5912000, 1'b1, 1'b0, 1'b0);
        chk9("ldr_ex_const", obs_ex, 9'b0_0_0010_011);
        step(32'hE1510002, 1'b1, 1'b0, 1'b0);
        chk9("cmp_ex_const", obs_ex, 9'b1_0_0100_000);
        step(32'hE3A01005, 1'b1, 1'b0, 1'b0);
        chk4("mov_two_src", {3'b000, two_src}, 4'h0);
        step(32'hE0821003, 1'b1, 1'b1, 1'b0);
        chk4("hazard_src2", src2, 4'h3);
        step(32'hE0821003, 1'b0, 1'b0, 1'b0);
        chk4("cond_two_src", {3'b000, two_src}, 4'h1);
        step(32'hEA000004, 1'b1, 1'b0, 1'b0);
        chk9("b_ex_const", obs_ex, 9'b0_1_0000_000);
        step(32'hEA000004, 1'b1, 1'b0, 1'b1);
        step(32'hE0821003, 1'b1, 1'b0, 1'b0);
        mid_reset();
        step(32'hE0821003, 1'b1, 1'b0, 1'b0);

        // Random instructions with occasional hazard, cond fail, flush, reset
        for (int n = 0; n < 300; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            if ($urandom_range(0, 3) != 0) ins[27] = 1'b0;
            step(ins, $urandom_range(0, 4) != 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 40) == 0) mid_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
